// File: rtl/seven_seg.sv
//------------------------------------------------------------------------------
// Module      : seven_seg
// Description : Four-digit multiplexed seven-segment driver for an MM:SS display
//               with blink blanking; registered active-low cathodes and anodes.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seven_seg (
  input  logic       fast,
  input  logic       reset,
  input  logic [2:0] min1,
  input  logic [3:0] min2,
  input  logic [2:0] sec1,
  input  logic [3:0] sec2,
  input  logic       blink,
  output logic [6:0] seg,
  output logic [3:0] dig
);

  localparam logic [6:0] C_SEG_BLANK = 7'b1111111;
  localparam logic [3:0] C_DIG_OFF   = 4'b1111;

  logic [1:0] r_sel;
  logic [6:0] r_seg;
  logic [3:0] r_dig;

  logic [3:0] w_val;
  logic [6:0] w_seg_pat;
  logic [3:0] w_dig_pat;

  // Position 0 is the rightmost digit (seconds units).
  always_comb begin
    w_val     = 4'd0;
    w_dig_pat = C_DIG_OFF;
    case (r_sel)
      2'd0: begin w_val = sec2;          w_dig_pat = 4'b1110; end
      2'd1: begin w_val = {1'b0, sec1};  w_dig_pat = 4'b1101; end
      2'd2: begin w_val = min2;          w_dig_pat = 4'b1011; end
      2'd3: begin w_val = {1'b0, min1};  w_dig_pat = 4'b0111; end
      default: begin w_val = 4'd0;       w_dig_pat = C_DIG_OFF; end
    endcase
  end

  // Pattern bits are g..a; non-BCD codes blank the digit but keep its anode.
  always_comb begin
    w_seg_pat = C_SEG_BLANK;
    case (w_val)
      4'd0:    w_seg_pat = 7'b1000000;
      4'd1:    w_seg_pat = 7'b1111001;
      4'd2:    w_seg_pat = 7'b0100100;
      4'd3:    w_seg_pat = 7'b0110000;
      4'd4:    w_seg_pat = 7'b0011001;
      4'd5:    w_seg_pat = 7'b0010010;
      4'd6:    w_seg_pat = 7'b0000010;
      4'd7:    w_seg_pat = 7'b1111000;
      4'd8:    w_seg_pat = 7'b0000000;
      4'd9:    w_seg_pat = 7'b0010000;
      default: w_seg_pat = C_SEG_BLANK;
    endcase
  end

  // The scan keeps running while blanked so the display resumes in phase.
  always_ff @(posedge fast) begin
    if (reset) begin
      r_sel <= 2'd0;
      r_seg <= C_SEG_BLANK;
      r_dig <= C_DIG_OFF;
    end else begin
      r_sel <= r_sel + 2'd1;
      if (blink) begin
        r_seg <= C_SEG_BLANK;
        r_dig <= C_DIG_OFF;
      end else begin
        r_seg <= w_seg_pat;
        r_dig <= w_dig_pat;
      end
    end
  end

  assign seg = r_seg;
  assign dig = r_dig;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg.sv
//------------------------------------------------------------------------------
// Module      : tb_seven_seg
// Description : Directed self-checking bench for seven_seg.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seven_seg;

  logic       fast = 1'b0;
  logic       reset;
  logic [2:0] min1;
  logic [3:0] min2;
  logic [2:0] sec1;
  logic [3:0] sec2;
  logic       blink;
  logic [6:0] seg;
  logic [3:0] dig;

  int errors = 0;
  int checks = 0;

  seven_seg dut (
    .fast  (fast),
    .reset (reset),
    .min1  (min1),
    .min2  (min2),
    .sec1  (sec1),
    .sec2  (sec2),
    .blink (blink),
    .seg   (seg),
    .dig   (dig)
  );

  always #5 fast = ~fast;

  // One rising edge, then settle on the falling edge for sampling/driving.
  task automatic step();
    @(posedge fast);
    @(negedge fast);
  endtask

  task automatic do_reset(input int edges);
    reset = 1'b1;
    for (int i = 0; i < edges; i++) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; blink = 1'b0;
    min1 = 3'd0; min2 = 4'd0; sec1 = 3'd0; sec2 = 4'd0;
    step(); step();
    checks++;
    if (dig !== 4'b1111) begin
      errors++; $display("FAIL reset_dig got=%b exp=1111", dig);
    end
    checks++;
    if (seg !== 7'b1111111) begin
      errors++; $display("FAIL reset_seg got=%b exp=1111111", seg);
    end
  endtask

  task automatic test_scan_zero();
    logic [3:0] ed [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (dig !== ed[i]) begin
        errors++; $display("FAIL scan0_dig[%0d] got=%b exp=%b", i, dig, ed[i]);
      end
      checks++;
      if (seg !== 7'b1000000) begin
        errors++; $display("FAIL scan0_seg[%0d] got=%b exp=1000000", i, seg);
      end
    end
  endtask

  task automatic test_single_digit();
    logic [3:0] ed [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] es [4] = '{7'b1000000, 7'b1000000, 7'b1111001, 7'b1000000};
    min1 = 3'd0; min2 = 4'd1; sec1 = 3'd0; sec2 = 4'd0;
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (dig !== ed[i] || seg !== es[i]) begin
        errors++;
        $display("FAIL single_pos%0d got dig=%b seg=%b exp dig=%b seg=%b",
                 i, dig, seg, ed[i], es[i]);
      end
    end
  endtask

  task automatic run_scan(input string name, input logic [6:0] es0,
                          input logic [6:0] es1, input logic [6:0] es2,
                          input logic [6:0] es3);
    logic [3:0] ed [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] es [4];
    es[0] = es0; es[1] = es1; es[2] = es2; es[3] = es3;
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (dig !== ed[i] || seg !== es[i]) begin
        errors++;
        $display("FAIL %s_pos%0d got dig=%b seg=%b exp dig=%b seg=%b",
                 name, i, dig, seg, ed[i], es[i]);
      end
    end
  endtask

  task automatic test_mixed();
    min1 = 3'd5; min2 = 4'd9; sec1 = 3'd3; sec2 = 4'd7;
    run_scan("mixed", 7'b1111000, 7'b0110000, 7'b0010000, 7'b0010010);
    min1 = 3'd2; min2 = 4'd8; sec1 = 3'd6; sec2 = 4'd4;
    run_scan("mixed2", 7'b0011001, 7'b0000010, 7'b0000000, 7'b0100100);
  endtask

  task automatic test_invalid();
    min1 = 3'd6; min2 = 4'd15; sec1 = 3'd7; sec2 = 4'd12;
    run_scan("invalid", 7'b1111111, 7'b1111000, 7'b1111111, 7'b0000010);
  endtask

  task automatic test_blink();
    min1 = 3'd1; min2 = 4'd2; sec1 = 3'd3; sec2 = 4'd4;
    do_reset(1);
    step(); step();
    blink = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (dig !== 4'b1111 || seg !== 7'b1111111) begin
        errors++;
        $display("FAIL blink_edge%0d got dig=%b seg=%b exp dig=1111 seg=1111111",
                 i, dig, seg);
      end
    end
    blink = 1'b0;
    step();
    checks++;
    if (dig !== 4'b1110 || seg !== 7'b0011001) begin
      errors++;
      $display("FAIL blink_resume got dig=%b seg=%b exp dig=1110 seg=0011001",
               dig, seg);
    end
    step();
    checks++;
    if (dig !== 4'b1101 || seg !== 7'b0110000) begin
      errors++;
      $display("FAIL blink_next got dig=%b seg=%b exp dig=1101 seg=0110000",
               dig, seg);
    end
  endtask

  task automatic test_mid_reset();
    min1 = 3'd0; min2 = 4'd0; sec1 = 3'd0; sec2 = 4'd0;
    do_reset(1);
    step(); step();
    reset = 1'b1;
    blink = 1'b0;
    step();
    checks++;
    if (dig !== 4'b1111 || seg !== 7'b1111111) begin
      errors++;
      $display("FAIL midreset got dig=%b seg=%b exp dig=1111 seg=1111111",
               dig, seg);
    end
    reset = 1'b0;
    step();
    checks++;
    if (dig !== 4'b1110 || seg !== 7'b1000000) begin
      errors++;
      $display("FAIL midreset_release got dig=%b seg=%b exp dig=1110 seg=1000000",
               dig, seg);
    end
  endtask

  task automatic test_late_sample();
    // A change to sec2 while it is not being scanned shows up on its next turn.
    min1 = 3'd0; min2 = 4'd0; sec1 = 3'd0; sec2 = 4'd3;
    do_reset(1);
    step();
    sec2 = 4'd9;
    step(); step(); step();
    step();
    checks++;
    if (dig !== 4'b1110 || seg !== 7'b0010000) begin
      errors++;
      $display("FAIL late_sample got dig=%b seg=%b exp dig=1110 seg=0010000",
               dig, seg);
    end
  endtask

  initial begin
    test_reset();
    test_scan_zero();
    test_single_digit();
    test_mixed();
    test_invalid();
    test_blink();
    test_mid_reset();
    test_late_sample();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seven_seg.md
SEVEN_SEG -- requirements
Module: seven_seg

Interface
REQ-001 fast  input  1  Sole clock (display multiplex rate); all state changes on its rising edge.
REQ-002 reset  input  1  Synchronous, active-high reset, sampled on rising edge of fast.
REQ-003 min1  input  3  Minutes tens digit, unsigned 0-7.
REQ-004 min2  input  4  Minutes units digit, BCD 0-9; codes 10-15 invalid.
REQ-005 sec1  input  3  Seconds tens digit, unsigned 0-7.
REQ-006 sec2  input  4  Seconds units digit, BCD 0-9; codes 10-15 invalid.
REQ-007 blink  input  1  High = display blanked (adjust-mode flash); low = normal display.
REQ-008 seg  output  7  Cathodes, active-low; seg[0]=a, seg[1]=b, ... seg[6]=g.
REQ-009 dig  output  4  Anodes, active-low, one-hot-low when active; dig[0]=rightmost digit.

Function
REQ-010 The block SHALL hold a 2-bit scan counter sel that increments by 1 on every rising edge of fast when reset is low, wrapping 3 -> 0.
REQ-011 sel SHALL increment regardless of blink.
REQ-012 The sel-to-position mapping SHALL be: 0 -> sec2 on dig[0]; 1 -> sec1 on dig[1]; 2 -> min2 on dig[2]; 3 -> min1 on dig[3].
REQ-013 seg and dig SHALL be registered: on each non-reset edge, they load the decode of the pre-increment sel value, giving one-cycle latency from sel to pins.
REQ-014 With blink low, dig SHALL load all ones except a 0 at bit sel: 1110, 1101, 1011, 0111 for sel 0-3.
REQ-015 With blink low, seg SHALL load the active-low pattern (g..a) of the selected digit value: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-016 3-bit inputs (min1, sec1) SHALL be zero-extended before decode; values 0-7 all display normally.
REQ-017 A 4-bit value of 10-15 SHALL produce seg=1111111 (blank) while dig still selects that position.
REQ-018 With blink high at an edge, dig SHALL load 1111 and seg SHALL load 1111111.
REQ-019 Digit inputs SHALL be sampled only at the edge that loads their position; changes take effect the next time that position is scanned.
REQ-020 No other state beyond sel, seg and dig registers SHALL exist.

Reset
REQ-021 With reset high at a rising edge of fast, sel SHALL become 0, dig 1111 and seg 1111111, overriding blink and all digit inputs.
REQ-022 After reset deasserts, the first edge SHALL drive position 0 (dig=1110), then positions 1, 2, 3, 0, ... in order.
REQ-023 Reset asserted mid-scan SHALL take effect at the next edge with no partial-cycle output.

Verification
REQ-024 All inputs 0, reset high for 2 edges -> dig=1111, seg=1111111; release, edge 1 -> dig=1110, seg=1000000; edges 2-4 -> dig 1101, 1011, 0111, each with seg=1000000; edge 5 -> dig=1110.
REQ-025 min1=0, min2=1, sec1=0, sec2=0 after reset -> edge 3 gives dig=1011, seg=1111001; all other positions give seg=1000000.
REQ-026 min1=5, min2=9, sec1=3, sec2=7 -> over four edges: dig=1110/seg=1111000, dig=1101/seg=0110000, dig=1011/seg=0010000, dig=0111/seg=0010010.
REQ-027 blink=1 for two edges mid-scan -> dig=1111, seg=1111111 on both; on blink=0 the display resumes at the position two places later (sel kept advancing).
REQ-028 sec2=12 -> at position 0 dig=1110, seg=1111111; sec1=7 -> at position 1 seg=1111000.
REQ-029 Reset pulse asserted while sel=2 -> next edge dig=1111, seg=1111111; the first edge after release drives dig=1110.
